// File: rtl/jogo_memoria_parametrizado.sv
// Memory game: an LFSR-built sequence is played back on the LEDs and the player
// must repeat it on the buttons. The FSM state is exported on estado.
module jogo_memoria_parametrizado #(
  parameter int          N_BOTOES    = 7,
  parameter int          MAX_RODADAS = 16,
  parameter int          T_LED       = 4,
  parameter int          T_TIMEOUT   = 20,
  parameter logic [15:0] SEED        = 16'hACE1,
  localparam int IW = (N_BOTOES > 1) ? $clog2(N_BOTOES) : 1,
  localparam int RW = $clog2(MAX_RODADAS),
  localparam int PW = $clog2(MAX_RODADAS + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jogar,
  input  logic                dificuldade,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [N_BOTOES-1:0] leds,
  output logic [3:0]          estado,
  output logic [PW-1:0]       pontuacao,
  output logic                pronto,
  output logic                ganhou,
  output logic                perdeu,
  output logic                timeout
);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    GERA        = 4'h2,
    MOSTRA      = 4'h3,
    APAGA       = 4'h4,
    ESPERA      = 4'h5,
    REGISTRA    = 4'h6,
    COMPARA     = 4'h7,
    PROXIMA     = 4'h8,
    FIM_GANHOU  = 4'h9,
    FIM_PERDEU  = 4'hA,
    FIM_TIMEOUT = 4'hB
  } state_t;

  localparam int LW = $clog2(T_LED + 1);
  localparam int TW = $clog2(T_TIMEOUT + 1);
  localparam logic [N_BOTOES-1:0] UM = 1;

  state_t              state_q, state_d;
  logic [15:0]         lfsr_q;
  logic                lfsr_fb;
  logic [IW-1:0]       mem_q [MAX_RODADAS];
  logic [RW-1:0]       rodada_q, rodada_d, endereco_q, endereco_d;
  logic [PW-1:0]       pont_q, pont_d, limite_q, limite_d;
  logic [LW-1:0]       led_cnt_q, led_cnt_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [N_BOTOES-1:0] botoes_prev_q, captura_q, captura_d;
  logic                mem_we;
  logic [IW-1:0]       sorteio;
  logic [N_BOTOES-1:0] alvo;
  logic                press;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign sorteio = IW'(lfsr_q % 16'(N_BOTOES));
  assign alvo    = UM << mem_q[endereco_q];
  // Rising edge of "any button": a button held into ESPERA never counts.
  assign press   = (botoes != '0) && (botoes_prev_q == '0);

  always_comb begin
    state_d    = state_q;
    rodada_d   = rodada_q;
    endereco_d = endereco_q;
    pont_d     = pont_q;
    limite_d   = limite_q;
    led_cnt_d  = led_cnt_q;
    tmo_d      = tmo_q;
    captura_d  = captura_q;
    mem_we     = 1'b0;
    case (state_q)
      INICIAL: if (jogar) state_d = PREPARA;
      PREPARA: begin
        rodada_d   = '0;
        endereco_d = '0;
        pont_d     = '0;
        captura_d  = '0;
        tmo_d      = '0;
        led_cnt_d  = '0;
        limite_d   = dificuldade ? PW'(MAX_RODADAS) : PW'(MAX_RODADAS / 2);
        state_d    = GERA;
      end
      GERA: begin
        mem_we     = 1'b1;
        endereco_d = '0;
        led_cnt_d  = '0;
        state_d    = MOSTRA;
      end
      MOSTRA: begin
        if (led_cnt_q == LW'(T_LED - 1)) begin
          led_cnt_d = '0;
          state_d   = APAGA;
        end else begin
          led_cnt_d = led_cnt_q + 1'b1;
        end
      end
      APAGA: begin
        if (led_cnt_q == LW'(T_LED - 1)) begin
          led_cnt_d = '0;
          tmo_d     = '0;
          if (endereco_q == rodada_q) begin
            endereco_d = '0;
            state_d    = ESPERA;
          end else begin
            endereco_d = endereco_q + 1'b1;
            state_d    = MOSTRA;
          end
        end else begin
          led_cnt_d = led_cnt_q + 1'b1;
        end
      end
      ESPERA: begin
        tmo_d = tmo_q + 1'b1;
        if (press) begin
          captura_d = botoes;
          state_d   = REGISTRA;
        end else if (tmo_q == TW'(T_TIMEOUT - 1)) begin
          state_d = FIM_TIMEOUT;
        end
      end
      REGISTRA: begin
        tmo_d   = '0;
        state_d = COMPARA;
      end
      COMPARA: begin
        if (captura_q != alvo) begin
          state_d = FIM_PERDEU;
        end else if (endereco_q == rodada_q) begin
          state_d = PROXIMA;
        end else begin
          endereco_d = endereco_q + 1'b1;
          state_d    = ESPERA;
        end
      end
      PROXIMA: begin
        pont_d = pont_q + 1'b1;
        if (PW'(rodada_q) + 1'b1 == limite_q) begin
          state_d = FIM_GANHOU;
        end else begin
          rodada_d = rodada_q + 1'b1;
          state_d  = GERA;
        end
      end
      FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: if (jogar) state_d = PREPARA;
      default: state_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= INICIAL;
      lfsr_q        <= SEED;
      rodada_q      <= '0;
      endereco_q    <= '0;
      pont_q        <= '0;
      limite_q      <= '0;
      led_cnt_q     <= '0;
      tmo_q         <= '0;
      botoes_prev_q <= '0;
      captura_q     <= '0;
      for (int i = 0; i < MAX_RODADAS; i++) mem_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= {lfsr_q[14:0], lfsr_fb};
      rodada_q      <= rodada_d;
      endereco_q    <= endereco_d;
      pont_q        <= pont_d;
      limite_q      <= limite_d;
      led_cnt_q     <= led_cnt_d;
      tmo_q         <= tmo_d;
      botoes_prev_q <= botoes;
      captura_q     <= captura_d;
      if (mem_we) mem_q[rodada_q] <= sorteio;
    end
  end

  always_comb begin
    leds = '0;
    case (state_q)
      MOSTRA:  leds = alvo;
      ESPERA:  leds = botoes;
      default: leds = '0;
    endcase
  end

  assign estado    = state_q;
  assign pontuacao = pont_q;
  assign ganhou    = (state_q == FIM_GANHOU);
  assign perdeu    = (state_q == FIM_PERDEU);
  assign timeout   = (state_q == FIM_TIMEOUT);
  assign pronto    = ganhou | perdeu | timeout;

endmodule

// File: tb/tb_jogo_memoria_parametrizado.sv
// Bench for jogo_memoria_parametrizado: table of whole-game scenarios replayed
// from observed playback, plus hand sequences for timeout edge and reset corners.
`timescale 1ns/1ps
module tb_jogo_memoria_parametrizado;
  localparam int N    = 7;
  localparam int MAXR = 16;
  localparam int TL   = 4;
  localparam int TT   = 20;
  localparam int PW   = $clog2(MAXR + 1);

  localparam int M_WIN = 0, M_WRONG = 1, M_MULTI = 2, M_TMO = 3, M_RST = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          jogar = 1'b0;
  logic          dificuldade = 1'b0;
  logic [N-1:0]  botoes = '0;
  logic [N-1:0]  leds;
  logic [3:0]    estado;
  logic [PW-1:0] pontuacao;
  logic          pronto, ganhou, perdeu, timeout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0]  lfsr_m;
  int           exp_seq [MAXR];
  logic [N-1:0] exp_q [$];

  typedef struct {
    logic       dif;
    int         mode;
    int         fail_rnd;
    int         fail_press;
    logic       hold;
    logic [3:0] exp_estado;
    int         exp_pont;
    logic [3:0] exp_flags;  // {pronto, ganhou, perdeu, timeout}
  } vec_t;

  vec_t vecs [7];

  jogo_memoria_parametrizado #(
    .N_BOTOES(N), .MAX_RODADAS(MAXR), .T_LED(TL), .T_TIMEOUT(TT), .SEED(16'hACE1)
  ) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .dificuldade(dificuldade),
    .botoes(botoes), .leds(leds), .estado(estado), .pontuacao(pontuacao),
    .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout)
  );

  always #5 clock = ~clock;

  // Reference Fibonacci LFSR, taps 16,14,13,11.
  always @(posedge clock or negedge reset) begin
    if (!reset) lfsr_m <= 16'hACE1;
    else        lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [N-1:0] oh(input int idx);
    logic [N-1:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  task automatic wait_left(input logic [3:0] s);
    int n;
    n = 0;
    while (estado == s && n < 64) begin
      step();
      n++;
    end
  endtask

  task automatic final_checks(input vec_t v);
    check("final_estado", estado, v.exp_estado);
    check("final_pont", pontuacao, v.exp_pont);
    check("final_flags", {pronto, ganhou, perdeu, timeout}, v.exp_flags);
    check("final_leds", leds, 0);
  endtask

  task automatic start_game(input logic dif);
    dificuldade = dif;
    jogar = 1'b1;
    step();
    check("start_prepara", estado, 1);
    jogar = 1'b0;
    step();
    check("start_gera", estado, 2);
    check("start_pont", pontuacao, 0);
    check("start_flags", {pronto, ganhou, perdeu, timeout}, 0);
  endtask

  task automatic play(input vec_t v);
    int rnd, n;
    logic [N-1:0] val, tgt;
    start_game(v.dif);
    rnd = 0;
    while (rnd < MAXR) begin
      check("gera", estado, 2);
      exp_seq[rnd] = int'(lfsr_m % N);
      step();
      exp_q = {};
      for (int e = 0; e <= rnd; e++) exp_q.push_back(oh(exp_seq[e]));
      for (int e = 0; e <= rnd; e++) begin
        tgt = exp_q.pop_front();
        n = 0;
        while (estado == 4'h3 && n <= TL) begin
          check("mostra_leds", leds, tgt);
          if (v.mode == M_RST && rnd + 1 == v.fail_rnd && n == 2) begin
            #2 reset = 1'b0;
            #1 final_checks(v);
            step();
            reset = 1'b1;
            step();
            check("post_reset_estado", estado, 0);
            return;
          end
          if (v.hold && rnd == 1 && e == 0 && n == 0) begin
            botoes = oh(exp_seq[0]);
            jogar  = 1'b1;
          end
          step();
          jogar = 1'b0;
          n++;
        end
        check("mostra_len", n, TL);
        n = 0;
        while (estado == 4'h4 && n <= TL) begin
          check("apaga_leds", leds, 0);
          step();
          n++;
        end
        check("apaga_len", n, TL);
      end
      check("espera_entry", estado, 5);
      if (v.hold && rnd == 1) begin
        step();
        check("hold_ignored", estado, 5);
        step();
        check("hold_ignored", estado, 5);
        botoes = '0;
        step();
        check("hold_release", estado, 5);
      end
      for (int p = 0; p <= rnd; p++) begin
        tgt = oh(exp_seq[p]);
        val = tgt;
        if (rnd + 1 == v.fail_rnd && p + 1 == v.fail_press) begin
          if (v.mode == M_TMO) begin
            n = 0;
            while (estado == 4'h5 && n <= TT) begin
              step();
              n++;
            end
            check("timeout_len", n, TT);
            final_checks(v);
            return;
          end else if (v.mode == M_WRONG) begin
            val = oh((exp_seq[p] + 1) % N);
          end else if (v.mode == M_MULTI) begin
            val = tgt | oh((exp_seq[p] + 1) % N);
          end
        end
        botoes = val;
        #1 check("echo", leds, val);
        step();
        check("registra", estado, 6);
        botoes = '0;
        step();
        check("compara", estado, 7);
        step();
        if (val != tgt) begin
          final_checks(v);
          return;
        end
        check("after_compara", estado, (p == rnd) ? 8 : 5);
      end
      check("proxima_pont", pontuacao, rnd);
      step();
      check("pont_inc", pontuacao, rnd + 1);
      if (rnd + 1 == (v.dif ? MAXR : MAXR / 2)) begin
        final_checks(v);
        return;
      end
      rnd++;
    end
    n_checks++;
    n_fail++;
    $display("FAIL game_end: got no end after %0d rounds expected end state", rnd);
  endtask

  initial begin
    vecs[0] = '{1'b0, M_WIN,   0, 0, 1'b0, 4'h9, 8,  4'b1100};
    vecs[1] = '{1'b1, M_WIN,   0, 0, 1'b1, 4'h9, 16, 4'b1100};
    vecs[2] = '{1'b0, M_WRONG, 3, 2, 1'b0, 4'hA, 2,  4'b1010};
    vecs[3] = '{1'b0, M_MULTI, 3, 2, 1'b0, 4'hA, 2,  4'b1010};
    vecs[4] = '{1'b1, M_TMO,   2, 1, 1'b0, 4'hB, 1,  4'b1001};
    vecs[5] = '{1'b0, M_RST,   3, 1, 1'b0, 4'h0, 0,  4'b0000};
    vecs[6] = '{1'b1, M_WRONG, 1, 1, 1'b0, 4'hA, 0,  4'b1010};

    // Clock/reset
    reset = 1'b0;
    step();
    step();
    check("reset_estado", estado, 0);
    check("reset_leds", leds, 0);
    check("reset_pont", pontuacao, 0);
    check("reset_flags", {pronto, ganhou, perdeu, timeout}, 0);
    reset = 1'b1;
    step();
    check("idle_estado", estado, 0);

    for (int i = 0; i < 7; i++) begin
      play(vecs[i]);
      step();
      check("end_hold_estado", estado, vecs[i].exp_estado);
      check("end_hold_pont", pontuacao, vecs[i].exp_pont);
    end

    // Press on the last allowed cycle of ESPERA beats the timeout.
    start_game(1'b0);
    exp_seq[0] = int'(lfsr_m % N);
    wait_left(4'h2);
    wait_left(4'h3);
    wait_left(4'h4);
    check("edge_espera", estado, 5);
    for (int i = 1; i < TT; i++) step();
    check("edge_still_espera", estado, 5);
    botoes = oh(exp_seq[0]);
    step();
    check("edge_press_wins", estado, 6);
    botoes = '0;
    step();
    step();
    check("edge_round_done", estado, 8);

    // Reset together with jogar keeps the FSM in INICIAL.
    #2 reset = 1'b0;
    jogar = 1'b1;
    #1 check("rst_jogar_now", estado, 0);
    check("rst_jogar_pont", pontuacao, 0);
    step();
    step();
    check("rst_jogar_held", estado, 0);
    jogar = 1'b0;
    reset = 1'b1;
    step();
    check("rst_release", estado, 0);
    check("rst_release_leds", leds, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jogo_memoria_parametrizado.md
JOGO_MEMORIA_PARAMETRIZADO -- requirements
Module: jogo_memoria_parametrizado

Interface
REQ-001 SHALL have parameter N_BOTOES, default 7: number of buttons/LEDs, legal 2..16.
REQ-002 SHALL have parameter MAX_RODADAS, default 16: maximum sequence length, even, legal 2..64.
REQ-003 SHALL have parameter T_LED, default 4: clock cycles each element is lit, and each gap is dark, during playback.
REQ-004 SHALL have parameter T_TIMEOUT, default 20: cycles allowed per press in ESPERA.
REQ-005 SHALL have parameter SEED, default 16'hACE1: LFSR reset value, nonzero.
REQ-006 SHALL have ports, clock and reset first: clock  in  1  sole clock, all state on rising edge.
REQ-007 SHALL have: reset  in  1  asynchronous, active-low; clock and reset use these names.
REQ-008 SHALL have: jogar  in  1  start/restart request, level-sampled.
REQ-009 SHALL have: dificuldade  in  1  0 = MAX_RODADAS/2 rounds, 1 = MAX_RODADAS rounds; sampled in PREPARA.
REQ-010 SHALL have: botoes  in  N_BOTOES  player buttons, synchronous to clock.
REQ-011 SHALL have: leds  out  N_BOTOES  one-hot playback or echo of botoes.
REQ-012 SHALL have: estado  out  4  current FSM state code.
REQ-013 SHALL have: pontuacao  out  $clog2(MAX_RODADAS+1)  completed rounds.
REQ-014 SHALL have: pronto, ganhou, perdeu, timeout  out  1 each  end-of-game flags.

Function
REQ-015 SHALL implement FSM codes: INICIAL=0, PREPARA=1, GERA=2, MOSTRA=3, APAGA=4, ESPERA=5, REGISTRA=6, COMPARA=7, PROXIMA=8, FIM_GANHOU=9, FIM_PERDEU=A, FIM_TIMEOUT=B; codes C-F SHALL go to INICIAL next cycle.
REQ-016 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11) advancing every cycle in every state.
REQ-017 SHALL hold a MAX_RODADAS x $clog2(N_BOTOES) register memory; GERA writes lfsr % N_BOTOES at index rodada, one cycle.
REQ-018 INICIAL: on jogar=1 -> PREPARA; otherwise stay.
REQ-019 PREPARA (1 cycle): clear rodada, endereco, pontuacao and all flags; latch limite from dificuldade; -> GERA.
REQ-020 GERA -> MOSTRA with endereco=0.
REQ-021 MOSTRA: leds = one-hot(mem[endereco]) for exactly T_LED cycles -> APAGA.
REQ-022 APAGA: leds = 0 for T_LED cycles; then if endereco==rodada -> ESPERA with endereco=0, else endereco+1 -> MOSTRA.
REQ-023 ESPERA: leds = botoes; timeout counter increments each cycle; a press is botoes!=0 with previous-cycle botoes==0.
REQ-024 ESPERA press -> REGISTRA, capturing botoes that cycle; counter reaching T_TIMEOUT without a press -> FIM_TIMEOUT.
REQ-025 A press in the same cycle the counter reaches T_TIMEOUT SHALL win (-> REGISTRA).
REQ-026 REGISTRA -> COMPARA after one cycle; the timeout counter clears.
REQ-027 COMPARA: captured value != one-hot(mem[endereco]), multi-hot included -> FIM_PERDEU.
REQ-028 COMPARA on match: endereco<rodada -> endereco+1, ESPERA; endereco==rodada -> PROXIMA.
REQ-029 PROXIMA: pontuacao+1; if rodada+1==limite -> FIM_GANHOU, else rodada+1 -> GERA.
REQ-030 Presses during MOSTRA/APAGA SHALL be ignored; a button held into ESPERA SHALL NOT count until released and re-pressed.
REQ-031 End states: pronto=1 plus the matching one of ganhou/perdeu/timeout; pontuacao held; leds=0; jogar=1 -> PREPARA.
REQ-032 jogar SHALL be ignored in all states except INICIAL and end states.
REQ-033 leds SHALL be 0 in all states not named in REQ-021/023.

Reset
REQ-034 reset=0 SHALL immediately force INICIAL, LFSR=SEED, memory index registers, counters and pontuacao to 0, all outputs 0; this holds in any state, mid-game included.
REQ-035 reset=0 coincident with jogar=1 SHALL leave the FSM in INICIAL.

Verification
REQ-036 Reset mid-MOSTRA -> estado=0, leds=0, pontuacao=0, all flags 0 within the same cycle.
REQ-037 dificuldade=0, jogar; bench replays each observed playback -> after round 8, estado=9, ganhou=1, pronto=1, pontuacao=8.
REQ-038 dificuldade=1, perfect replay -> estado=9 after 16 rounds, pontuacao=16.
REQ-039 Round 3, second press wrong (or two buttons at once) -> estado=A, perdeu=1, pontuacao=2.
REQ-040 No press for 20 cycles in ESPERA -> estado=B, timeout=1; press exactly on cycle 20 -> estado=6.
REQ-041 jogar from FIM_PERDEU -> estado=1 then 2, all flags and pontuacao 0; each MOSTRA element lit exactly 4 cycles, one-hot.
